// File: rtl/mem_stage_ctrl_if.sv
// MEM-stage bundle: EX/MEM latch fields, datapath-cache port and MEM/WB latch outputs.
// master = mem_stage_ctrl, slave = surrounding pipeline/cache.
interface mem_stage_ctrl_if #(
    parameter int DW = 32
);
    logic          exm_valid;
    logic          exm_dREN;
    logic          exm_dWEN;
    logic [DW-1:0] exm_addr;
    logic [DW-1:0] exm_store;
    logic [1:0]    exm_MemToReg;
    logic          exm_RegWr;
    logic [4:0]    exm_wsel;
    logic          exm_halt;
    logic [DW-1:0] exm_lui;
    logic [DW-1:0] exm_pcp4;

    logic          dhit;
    logic [DW-1:0] dmemload;
    logic          dmemREN;
    logic          dmemWEN;
    logic [DW-1:0] dmemaddr;
    logic [DW-1:0] dmemstore;

    logic          wb_ready;
    logic          mem_stall;
    logic          mwb_valid;
    logic [DW-1:0] mwb_wdat;
    logic [4:0]    mwb_wsel;
    logic          mwb_RegWr;
    logic          mwb_halt;
    logic          mem_timeout;

    modport master (
        input  exm_valid, exm_dREN, exm_dWEN, exm_addr, exm_store, exm_MemToReg,
               exm_RegWr, exm_wsel, exm_halt, exm_lui, exm_pcp4,
               dhit, dmemload, wb_ready,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               mwb_valid, mwb_wdat, mwb_wsel, mwb_RegWr, mwb_halt, mem_timeout
    );

    modport slave (
        output exm_valid, exm_dREN, exm_dWEN, exm_addr, exm_store, exm_MemToReg,
               exm_RegWr, exm_wsel, exm_halt, exm_lui, exm_pcp4,
               dhit, dmemload, wb_ready,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               mwb_valid, mwb_wdat, mwb_wsel, mwb_RegWr, mwb_halt, mem_timeout
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-cache handshake, upstream stall, writeback select and MEM/WB latch.
// Optional request abort after TIMEOUT_CYCLES cycles without dhit when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl #(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              CLK,
    input logic              RST,
    mem_stage_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HALT = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state_q, state_d;
    logic          op_ren_q, op_ren_d;
    logic          op_wen_q, op_wen_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] store_q, store_d;
    logic [DW-1:0] ldata_q, ldata_d;

    logic          mwb_valid_q, mwb_valid_d;
    logic [DW-1:0] mwb_wdat_q, mwb_wdat_d;
    logic [4:0]    mwb_wsel_q, mwb_wsel_d;
    logic          mwb_regwr_q, mwb_regwr_d;
    logic          mwb_halt_q, mwb_halt_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic          mem_start;
    logic          wb_update;
    logic          halt_accept;
    logic [DW-1:0] wb_sel_data;

    logic          dmem_ren;
    logic          dmem_wen;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_store;
    logic          mem_stall;

    assign mem_start   = (state_q == IDLE) & bus.exm_valid & (bus.exm_dREN | bus.exm_dWEN);
    // MEM/WB only advances while the stage owns a finished (or non-memory) instruction.
    assign wb_update   = bus.wb_ready & ~mem_stall & ((state_q == IDLE) | (state_q == DONE));
    assign halt_accept = wb_update & bus.exm_valid & bus.exm_halt;

    always_comb begin
        wb_sel_data = bus.exm_addr;
        case (bus.exm_MemToReg)
            2'd0:    wb_sel_data = bus.exm_addr;
            2'd1:    wb_sel_data = ldata_q;
            2'd2:    wb_sel_data = bus.exm_lui;
            default: wb_sel_data = bus.exm_pcp4;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            op_ren_q    <= 1'b0;
            op_wen_q    <= 1'b0;
            addr_q      <= '0;
            store_q     <= '0;
            ldata_q     <= '0;
            mwb_valid_q <= 1'b0;
            mwb_wdat_q  <= '0;
            mwb_wsel_q  <= '0;
            mwb_regwr_q <= 1'b0;
            mwb_halt_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_ren_q    <= op_ren_d;
            op_wen_q    <= op_wen_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            ldata_q     <= ldata_d;
            mwb_valid_q <= mwb_valid_d;
            mwb_wdat_q  <= mwb_wdat_d;
            mwb_wsel_q  <= mwb_wsel_d;
            mwb_regwr_q <= mwb_regwr_d;
            mwb_halt_q  <= mwb_halt_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        op_ren_d = op_ren_q;
        op_wen_d = op_wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        ldata_d  = ldata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (mem_start) begin
                    op_ren_d = bus.exm_dREN;
                    op_wen_d = bus.exm_dWEN;
                    addr_d   = bus.exm_addr;
                    store_d  = bus.exm_store;
                    state_d  = REQ;
`ifdef MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            REQ: begin
                if (bus.dhit) begin
                    ldata_d = bus.dmemload;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort leaves a recognisable poison value for the load path.
                    ldata_d   = DW'(32'hBAD1BAD1);
                    timeout_d = 1'b1;
                    cnt_d     = CW'(TIMEOUT_CYCLES);
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = HALT;
        endcase

        if (halt_accept) begin
            state_d = HALT;
        end
    end

    always_comb begin
        mwb_valid_d = mwb_valid_q;
        mwb_wdat_d  = mwb_wdat_q;
        mwb_wsel_d  = mwb_wsel_q;
        mwb_regwr_d = mwb_regwr_q;
        mwb_halt_d  = mwb_halt_q;

        if (wb_update) begin
            mwb_valid_d = bus.exm_valid;
            mwb_wdat_d  = wb_sel_data;
            mwb_wsel_d  = bus.exm_wsel;
            mwb_regwr_d = bus.exm_valid & bus.exm_RegWr;
            mwb_halt_d  = mwb_halt_q | halt_accept;
        end
    end

    // A load+store encoding is issued as a store only.
    always_comb begin
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        mem_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                mem_stall = mem_start;
            end
            REQ: begin
                dmem_ren   = op_ren_q & ~op_wen_q;
                dmem_wen   = op_wen_q;
                dmem_addr  = addr_q;
                dmem_store = store_q;
                mem_stall  = 1'b1;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    assign bus.dmemREN   = dmem_ren;
    assign bus.dmemWEN   = dmem_wen;
    assign bus.dmemaddr  = dmem_addr;
    assign bus.dmemstore = dmem_store;
    assign bus.mem_stall = mem_stall;
    assign bus.mwb_valid = mwb_valid_q;
    assign bus.mwb_wdat  = mwb_wdat_q;
    assign bus.mwb_wsel  = mwb_wsel_q;
    assign bus.mwb_RegWr = mwb_regwr_q;
    assign bus.mwb_halt  = mwb_halt_q;

`ifdef MEM_TIMEOUT_EN
    assign bus.mem_timeout = timeout_q;
`else
    assign bus.mem_timeout = 1'b0;
`endif

endmodule
